instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001: Parameter A_WIDTH, default 28, is the instruction-memory byte-address width.
REQ-002: Parameter D_WIDTH, default 8, is the memory byte width and stream width.
REQ-003: clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004: rst_n  input  1  is the asynchronous, active-low reset.
REQ-005: in_valid  input  1  means the source offers a stream byte.
REQ-006: in_data  input  D_WIDTH  is the stream byte.
REQ-007: in_ready  output  1  means the loader accepts in_data this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-008: mem_we  output  1  is the single-cycle byte write strobe to instruction memory.
REQ-009: mem_addr  output  A_WIDTH  is the byte address of the write.
REQ-010: mem_wdata  output  D_WIDTH  is the byte to write.
REQ-011: cpu_rst_n  output  1  holds the core in reset while low.
REQ-012: done  output  1  means the image loaded and the checksum matched.
REQ-013: err  output  1  means the load failed.

Function
REQ-014: The stream format SHALL be 4 length bytes (N, little-endian, 32-bit), then N payload bytes, then 1 checksum byte.
REQ-015: The FSM SHALL use states LEN, DATA, CHK, DONE and ERR, and SHALL enter LEN at reset.
REQ-016: in_ready SHALL be high in LEN, DATA and CHK, and low in DONE and ERR.
REQ-017: LEN: the FSM SHALL shift in 4 bytes, with byte 0 in bits [7:0]; on the 4th transfer it SHALL go to DATA if N>0, to CHK if N=0, or to ERR if N>2**A_WIDTH.
REQ-018: DATA: each transfer SHALL produce mem_we=1 for exactly one cycle on the following cycle, with mem_addr equal to the payload index (0..N-1) and mem_wdata equal to the byte.
REQ-019: The write latency SHALL be 1 cycle, and back-to-back transfers SHALL yield back-to-back writes with no bubbles.
REQ-020: After the N-th payload transfer, the FSM SHALL go to CHK.
REQ-021: The checksum SHALL be the modulo-256 sum of the payload bytes only; N=0 gives a sum of 0x00.
REQ-022: CHK: on the transfer, the FSM SHALL go to DONE if the received byte equals the sum, else to ERR.
REQ-023: DONE SHALL assert done=1 and cpu_rst_n=1 from the cycle after the checksum transfer onward.
REQ-024: ERR SHALL assert err=1 with cpu_rst_n=0.
REQ-025: DONE and ERR SHALL be terminal and left only via rst_n.
REQ-026: in_valid low SHALL stall the FSM with no state, counter or checksum change, and no mem_we.
REQ-027: The payload counter SHALL be 33 bits wide, so N=2**A_WIDTH is accepted and its last address is 2**A_WIDTH-1 with no wrap.
REQ-028: mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-029: On rst_n low, outputs SHALL immediately be: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, done=0, err=0.
REQ-030: On rst_n low, the state SHALL be LEN and the length register, counter and checksum SHALL be 0.
REQ-031: in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-032: Reset asserted mid-load SHALL abort the load, and any write not yet issued SHALL be dropped.

Structure
REQ-033: The state enum and the LEN_BYTES=4 constant SHALL live in the shared package, alongside the memory width constants.
REQ-034: The block SHALL be one module with no sub-modules.
REQ-035: The memory write port SHALL connect to a byte-wide write port added to instruction memory, which stays byte-addressed and little-endian.

Verification
REQ-036: Bytes 04 00 00 00, 13 00 00 00, checksum 13 -> writes addr0=13 and addr1..3=00 on consecutive cycles; then done=1 and cpu_rst_n=1.
REQ-037: Bytes 02 00 00 00, AA 55, checksum 00 -> checksum mismatch, since the sum is FF -> err=1, cpu_rst_n=0, in_ready=0.
REQ-038: Bytes 00 00 00 00, checksum 00 -> no mem_we, then done=1; with checksum 01 instead -> err=1.
REQ-039: With A_WIDTH=4, length 11 00 00 00 (17 > 16) -> err=1 with no writes; with length 10 00 00 00 -> the last write is at addr 0xF.
REQ-040: Random in_valid gaps during the REQ-036 stream -> identical write sequence, and no mem_we while in_valid=0.
REQ-041: rst_n pulsed low after 2 payload bytes -> outputs reset immediately; a full new stream then loads from addr 0 and reaches done.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// loader states, stream framing constants and default memory widths.
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CHK  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } ldr_state_e;

  localparam int LEN_BYTES    = 4;
  localparam int LEN_WIDTH    = 8 * LEN_BYTES;
  localparam int CNT_WIDTH    = LEN_WIDTH + 1;
  localparam int SUM_WIDTH    = 8;
  localparam int IMEM_A_WIDTH = 28;
  localparam int IMEM_D_WIDTH = 8;

endpackage

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed, checksummed image into instruction memory one
// byte per transfer, then releases the core from reset if the checksum matches.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int A_WIDTH = IMEM_A_WIDTH,
  parameter int D_WIDTH = IMEM_D_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic               cpu_rst_n,
  output logic               done,
  output logic               err
);

  localparam logic [CNT_WIDTH-1:0] MAX_LEN  = {{(CNT_WIDTH-1){1'b0}}, 1'b1} << A_WIDTH;
  localparam logic [1:0]           LEN_LAST = 2'(LEN_BYTES - 1);

  ldr_state_e             state_q, state_d;
  logic                   rdy_en_q, rdy_en_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [1:0]             lcnt_q, lcnt_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic                   mem_we_q, mem_we_d;
  logic [A_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;

  logic                   xfer;
  logic [LEN_WIDTH-1:0]   len_full;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  // Ready is gated by a flop so it stays low until the first edge out of reset.
  assign in_ready = rdy_en_q &&
                    ((state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK));
  assign xfer     = in_valid && in_ready;
  assign len_full = {in_data[7:0], len_q[LEN_WIDTH-1:8]};
  assign cnt_inc  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = (state_q == ST_DONE);
  assign cpu_rst_n = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);

  always_comb begin
    state_d     = state_q;
    rdy_en_d    = 1'b1;
    len_d       = len_q;
    lcnt_d      = lcnt_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_LEN: begin
        if (xfer) begin
          len_d  = len_full;
          lcnt_d = lcnt_q + 2'd1;
          if (lcnt_q == LEN_LAST) begin
            if ({1'b0, len_full} > MAX_LEN) begin
              state_d = ST_ERR;
            end else if (len_full == '0) begin
              state_d = ST_CHK;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[A_WIDTH-1:0];
          mem_wdata_d = in_data;
          sum_d       = sum_q + in_data[7:0];
          cnt_d       = cnt_inc;
          if (cnt_inc == {1'b0, len_q}) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (xfer) begin
          state_d = (in_data[7:0] == sum_q) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LEN;
      rdy_en_q    <= 1'b0;
      len_q       <= '0;
      lcnt_q      <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= rdy_en_d;
      len_q       <= len_d;
      lcnt_q      <= lcnt_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: two instances (default and 4-bit address) share
// one stream; a byte-index model predicts every output cycle by cycle.
module tb_instr_mem_loader;

  typedef logic [7:0] bq_t[$];

  localparam int RUN = 0;
  localparam int OK  = 1;
  localparam int BAD = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready_a, mem_we_a, cpu_rst_n_a, done_a, err_a;
  logic [27:0] mem_addr_a;
  logic [7:0]  mem_wdata_a;
  logic        in_ready_b, mem_we_b, cpu_rst_n_b, done_b, err_b;
  logic [3:0]  mem_addr_b;
  logic [7:0]  mem_wdata_b;

  int n_cmp = 0;
  int n_bad = 0;

  instr_mem_loader dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .cpu_rst_n(cpu_rst_n_a), .done(done_a), .err(err_a)
  );

  instr_mem_loader #(.A_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .cpu_rst_n(cpu_rst_n_b), .done(done_b), .err(err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model state per instance: accepted byte index, length, sum, outcome.
  longint     m_idx [2];
  longint     m_n   [2];
  logic [7:0] m_sum [2];
  int         m_out [2];
  bit         m_rdy [2];
  bit         m_we  [2];
  longint     m_addr[2];
  logic [7:0] m_data[2];

  longint wa_addr[$];
  logic [7:0] wa_data[$];
  longint wb_addr[$];
  logic [7:0] wb_data[$];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      longint lim;
      longint amask;
      logic   o_rdy, o_we, o_cpu, o_done, o_err;
      longint o_addr;
      logic [7:0] o_data;
      bit     exp_rdy;
      bit     we_next;
      lim   = (k == 0) ? (64'sd1 <<< 28) : (64'sd1 <<< 4);
      amask = lim - 1;
      o_rdy  = (k == 0) ? in_ready_a  : in_ready_b;
      o_we   = (k == 0) ? mem_we_a    : mem_we_b;
      o_cpu  = (k == 0) ? cpu_rst_n_a : cpu_rst_n_b;
      o_done = (k == 0) ? done_a      : done_b;
      o_err  = (k == 0) ? err_a       : err_b;
      o_addr = (k == 0) ? longint'(mem_addr_a)  : longint'(mem_addr_b);
      o_data = (k == 0) ? mem_wdata_a : mem_wdata_b;

      if (!rst_n) begin
        m_idx[k] = 0; m_n[k] = 0; m_sum[k] = 8'h00; m_out[k] = RUN;
        m_rdy[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = 0; m_data[k] = 8'h00;
      end

      exp_rdy = m_rdy[k] && (m_out[k] == RUN);
      chk($sformatf("in_ready[%0d]", k),  longint'(o_rdy),  longint'(exp_rdy));
      chk($sformatf("mem_we[%0d]", k),    longint'(o_we),   longint'(m_we[k]));
      chk($sformatf("mem_addr[%0d]", k),  o_addr,           m_addr[k] & amask);
      chk($sformatf("mem_wdata[%0d]", k), longint'(o_data), longint'(m_data[k]));
      chk($sformatf("done[%0d]", k),      longint'(o_done), longint'(m_out[k] == OK));
      chk($sformatf("cpu_rst_n[%0d]", k), longint'(o_cpu),  longint'(m_out[k] == OK));
      chk($sformatf("err[%0d]", k),       longint'(o_err),  longint'(m_out[k] == BAD));

      if (o_we) begin
        if (k == 0) begin wa_addr.push_back(o_addr); wa_data.push_back(o_data); end
        else        begin wb_addr.push_back(o_addr); wb_data.push_back(o_data); end
      end

      if (rst_n) begin
        we_next = 1'b0;
        if (in_valid && exp_rdy) begin
          if (m_idx[k] < 4) begin
            m_n[k] = m_n[k] | (longint'(in_data) << (8 * m_idx[k]));
            m_idx[k]++;
            if (m_idx[k] == 4 && m_n[k] > lim) m_out[k] = BAD;
          end else if (m_idx[k] < 4 + m_n[k]) begin
            we_next   = 1'b1;
            m_addr[k] = m_idx[k] - 4;
            m_data[k] = in_data;
            m_sum[k]  = m_sum[k] + in_data;
            m_idx[k]++;
          end else begin
            m_out[k] = (in_data == m_sum[k]) ? OK : BAD;
          end
        end
        m_we[k]  = we_next;
        m_rdy[k] = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    tick(gap);
    in_valid = 1'b1;
    in_data  = b;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input int maxgap);
    foreach (s[i]) send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst mem_we",    longint'(mem_we_a),    0);
    chk("rst in_ready",  longint'(in_ready_a),  0);
    chk("rst cpu_rst_n", longint'(cpu_rst_n_a), 0);
    chk("rst done",      longint'(done_a),      0);
    chk("rst err",       longint'(err_a),       0);
    chk("rst mem_addr",  longint'(mem_addr_a),  0);
    chk("rst mem_wdata", longint'(mem_wdata_a), 0);
    wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
    tick(2);
    rst_n = 1'b1;
    chk("ready before first edge", longint'(in_ready_a), 0);
    tick(1);
    chk("ready after first edge", longint'(in_ready_a), 1);
  endtask

  task automatic check_basic_image();
    chk("img write count", wa_addr.size(), 4);
    if (wa_addr.size() == 4) begin
      chk("img addr0", wa_addr[0], 0);  chk("img data0", longint'(wa_data[0]), 'h13);
      chk("img addr1", wa_addr[1], 1);  chk("img data1", longint'(wa_data[1]), 'h00);
      chk("img addr3", wa_addr[3], 3);  chk("img data3", longint'(wa_data[3]), 'h00);
    end
    chk("img done",      longint'(done_a),      1);
    chk("img cpu_rst_n", longint'(cpu_rst_n_a), 1);
  endtask

  initial begin
    bq_t s;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick(2);
    chk("por mem_we",   longint'(mem_we_a),   0);
    chk("por in_ready", longint'(in_ready_a), 0);
    rst_n = 1'b1;
    tick(1);

    s = {8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_stream(s, 0);
    tick(3);
    check_basic_image();
    chk("img b done", longint'(done_b), 1);

    do_reset();
    s = {8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h00};
    send_stream(s, 0);
    tick(2);
    chk("badsum err",       longint'(err_a),       1);
    chk("badsum cpu_rst_n", longint'(cpu_rst_n_a), 0);
    chk("badsum in_ready",  longint'(in_ready_a),  0);

    do_reset();
    s = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(s, 0);
    tick(2);
    chk("empty writes", wa_addr.size(), 0);
    chk("empty done",   longint'(done_a), 1);

    do_reset();
    s = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    send_stream(s, 0);
    tick(2);
    chk("empty badsum err", longint'(err_a), 1);

    do_reset();
    s = {8'h11, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 17; i++) s.push_back(8'h01);
    s.push_back(8'h11);
    send_stream(s, 0);
    tick(2);
    chk("oversize b err",    longint'(err_b), 1);
    chk("oversize b writes", wb_addr.size(), 0);
    chk("oversize a done",   longint'(done_a), 1);
    chk("oversize a writes", wa_addr.size(), 17);

    do_reset();
    s = {8'h10, 8'h00, 8'h00, 8'h00};
    for (int i = 1; i <= 16; i++) s.push_back(8'(i));
    s.push_back(8'h88);
    send_stream(s, 0);
    tick(2);
    chk("full b writes", wb_addr.size(), 16);
    if (wb_addr.size() == 16) begin
      chk("full b last addr", wb_addr[15], 'hF);
      chk("full b last data", longint'(wb_data[15]), 'h10);
    end
    chk("full b done", longint'(done_b), 1);

    do_reset();
    s = {8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_stream(s, 3);
    tick(3);
    check_basic_image();

    do_reset();
    s = {8'h04, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send_stream(s, 0);
    chk("abort pre-reset we", longint'(mem_we_a), 1);
    do_reset();
    s = {8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_stream(s, 0);
    tick(3);
    check_basic_image();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
